// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with parked idle bus (addr 8'hE0).
// Optional BUS_ARB_TIMEOUT_EN: hold counter forces handover after MAX_HOLD cycles.
// Ports: clk, reset_n (async low); m0_/m1_ req,address,wr,dout in;
//        m0_grant,m1_grant (state-decoded), address,wr,dout shared bus out.
module bus_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic [7:0]        m0_address,
  input  logic              m0_wr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_req,
  input  logic [7:0]        m1_address,
  input  logic              m1_wr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic [7:0]        address,
  output logic              wr,
  output logic [DATA_W-1:0] dout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_last;
  logic       w_expired;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold;

  assign w_expired = (r_hold == HOLD_TOP);

  // Clears on any grant entry, saturates at HOLD_TOP while owned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold <= 8'd0;
    end else if (w_next != r_state && w_next != IDLE) begin
      r_hold <= 8'd0;
    end else if (r_state == IDLE) begin
      r_hold <= 8'd0;
    end else if (!w_expired) begin
      r_hold <= r_hold + 8'd1;
    end
  end
`else
  logic w_unused_hold;

  assign w_unused_hold = |8'(MAX_HOLD);
  assign w_expired     = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (m0_req && m1_req)
          w_next = r_last ? GRANT0 : GRANT1;
        else if (m0_req)
          w_next = GRANT0;
        else if (m1_req)
          w_next = GRANT1;
      end
      GRANT0: begin
        if (m1_req && (w_expired || !m0_req))
          w_next = GRANT1;
        else if (!m0_req)
          w_next = IDLE;
      end
      GRANT1: begin
        if (m0_req && (w_expired || !m1_req))
          w_next = GRANT0;
        else if (!m1_req)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == GRANT0)
        r_last <= 1'b0;
      else if (w_next == GRANT1)
        r_last <= 1'b1;
    end
  end

  assign m0_grant = (r_state == GRANT0);
  assign m1_grant = (r_state == GRANT1);

  // Decoded from the state register only, so an async reset parks
  // the bus immediately.
  always_comb begin
    address = 8'hE0;
    wr      = 1'b0;
    dout    = '0;
    unique case (1'b1)
      m0_grant: begin
        address = m0_address;
        wr      = m0_wr;
        dout    = m0_dout;
      end
      m1_grant: begin
        address = m1_address;
        wr      = m1_wr;
        dout    = m1_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter.
// Directed scenarios plus randomized traffic against an ownership model.
module tb_bus_arbiter;

  localparam int DW = 32;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_req = 1'b0;
  logic [7:0]    m0_address = 8'h00;
  logic          m0_wr = 1'b0;
  logic [DW-1:0] m0_dout = '0;
  logic          m1_req = 1'b0;
  logic [7:0]    m1_address = 8'h00;
  logic          m1_wr = 1'b0;
  logic [DW-1:0] m1_dout = '0;
  logic          m0_grant;
  logic          m1_grant;
  logic [7:0]    address;
  logic          wr;
  logic [DW-1:0] dout;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_address(m0_address),
    .m0_wr(m0_wr), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_address(m1_address),
    .m1_wr(m1_wr), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .address(address), .wr(wr), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_address = 0; m0_wr = 0; m0_dout = '0;
    m1_req = 0; m1_address = 0; m1_wr = 0; m1_dout = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    tick();
    tick();
    reset_n = 1;
    #1;
  endtask

  // Ownership model: 0 = none, 1 = M0, 2 = M1.
  // tenure = cycles the current owner has held the bus so far.
  function automatic int model_next(int own, int last, int tenure,
                                    logic r0, logic r1);
    bit tmo;
`ifdef BUS_ARB_TIMEOUT_EN
    tmo = (tenure >= MH);
`else
    tmo = 0;
`endif
    if (own == 0) begin
      if (r0 && r1) return (last == 1) ? 1 : 2;
      if (r0) return 1;
      if (r1) return 2;
      return 0;
    end
    if (own == 1) begin
      if (r1 && (tmo || !r0)) return 2;
      return r0 ? 1 : 0;
    end
    if (r0 && (tmo || !r1)) return 1;
    return r1 ? 2 : 0;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m0_grant, m1_grant, address, wr, dout} !== {2'b00, 8'hE0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_values got g=%b%b a=%h w=%b d=%h want g=00 a=e0 w=0 d=0",
               m0_grant, m1_grant, address, wr, dout);
    end
    m0_req = 1; m0_address = 8'h25; m0_wr = 1; m0_dout = 32'hCAFE_0001;
    tick();
    checks++;
    if (m0_grant !== 1'b1 || address !== 8'h25) begin
      errors++;
      $display("FAIL reset_pre_grant got g0=%b a=%h want g0=1 a=25", m0_grant, address);
    end
    #2;
    reset_n = 0;
    #1;
    checks++;
    if ({m0_grant, m1_grant, address, wr, dout} !== {2'b00, 8'hE0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_async got g=%b%b a=%h w=%b d=%h want g=00 a=e0 w=0 d=0",
               m0_grant, m1_grant, address, wr, dout);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    m1_req = 1; m1_address = 8'h41; m1_wr = 1; m1_dout = 32'h1234_5678;
    #1;
    checks++;
    if (m1_grant !== 1'b0 || address !== 8'hE0) begin
      errors++;
      $display("FAIL single_latency got g1=%b a=%h want g1=0 a=e0", m1_grant, address);
    end
    tick();
    checks++;
    if ({m1_grant, m0_grant, address, wr, dout} !== {2'b10, 8'h41, 1'b1, 32'h1234_5678}) begin
      errors++;
      $display("FAIL single_grant got g1=%b g0=%b a=%h w=%b d=%h want 1 0 41 1 12345678",
               m1_grant, m0_grant, address, wr, dout);
    end
    m1_req = 0; m1_wr = 0;
    tick();
    checks++;
    if (m1_grant !== 1'b0 || address !== 8'hE0 || wr !== 1'b0) begin
      errors++;
      $display("FAIL single_release got g1=%b a=%h w=%b want 0 e0 0", m1_grant, address, wr);
    end
  endtask

  task automatic test_tie();
    do_reset();
    m0_req = 1; m1_req = 1;
    m0_address = 8'h22; m1_address = 8'h62;
    tick();
    checks++;
    if (m0_grant !== 1'b1 || m1_grant !== 1'b0 || address !== 8'h22) begin
      errors++;
      $display("FAIL tie_first got g0=%b g1=%b a=%h want 1 0 22", m0_grant, m1_grant, address);
    end
    m0_req = 0; m1_req = 0;
    tick();
    m0_req = 1; m1_req = 1;
    tick();
    checks++;
    if (m1_grant !== 1'b1 || m0_grant !== 1'b0 || address !== 8'h62) begin
      errors++;
      $display("FAIL tie_second got g0=%b g1=%b a=%h want 0 1 62", m0_grant, m1_grant, address);
    end
    m0_req = 0; m1_req = 0;
    tick();
  endtask

  task automatic test_handover();
    do_reset();
    m0_req = 1; m0_address = 8'h10;
    tick();
    m1_req = 1; m1_address = 8'h70;
    #1;
    checks++;
    if (m0_grant !== 1'b1 || address !== 8'h10) begin
      errors++;
      $display("FAIL handover_owner got g0=%b a=%h want 1 10", m0_grant, address);
    end
    m0_req = 0;
    tick();
    checks++;
    if ({m0_grant, m1_grant, address} !== {2'b01, 8'h70}) begin
      errors++;
      $display("FAIL handover_switch got g0=%b g1=%b a=%h want 0 1 70",
               m0_grant, m1_grant, address);
    end
    m1_req = 0;
    tick();
  endtask

  task automatic test_timeout();
    int g0_cycles;
    bit got1;
    do_reset();
    m0_req = 1; m0_address = 8'h05;
    tick();
    m1_req = 1; m1_address = 8'h45;
    g0_cycles = 0;
    got1 = 0;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 40 && !got1; i++) begin
      if (m1_grant) got1 = 1;
      else begin
        if (m0_grant) g0_cycles++;
        tick();
      end
    end
    checks++;
    if (!got1 || g0_cycles != MH) begin
      errors++;
      $display("FAIL timeout_preempt got m1_granted=%0d m0_cycles=%0d want 1 %0d",
               got1, g0_cycles, MH);
    end
`else
    for (int i = 0; i < 100; i++) begin
      if (m0_grant && !m1_grant) g0_cycles++;
      tick();
    end
    checks++;
    if (g0_cycles != 100) begin
      errors++;
      $display("FAIL timeout_hold got m0_cycles=%0d want 100", g0_cycles);
    end
    m0_req = 0;
    tick();
    checks++;
    if (m1_grant !== 1'b1 || address !== 8'h45) begin
      errors++;
      $display("FAIL timeout_release got g1=%b a=%h want 1 45", m1_grant, address);
    end
`endif
    m0_req = 0; m1_req = 0;
    tick();
  endtask

  task automatic test_random();
    int own, last, tenure, nxt, bad;
    logic [7:0] ea;
    logic ew;
    logic [DW-1:0] ed;
    do_reset();
    own = 0; last = 1; tenure = 0; bad = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) m0_req = ~m0_req;
      if ($urandom_range(3) == 0) m1_req = ~m1_req;
      m0_address = 8'($urandom); m0_wr = 1'($urandom); m0_dout = $urandom;
      m1_address = 8'($urandom); m1_wr = 1'($urandom); m1_dout = $urandom;
      #1;
      ea = 8'hE0; ew = 0; ed = '0;
      if (own == 1) begin ea = m0_address; ew = m0_wr; ed = m0_dout; end
      if (own == 2) begin ea = m1_address; ew = m1_wr; ed = m1_dout; end
      checks++;
      if (m0_grant !== (own == 1) || m1_grant !== (own == 2) ||
          address !== ea || wr !== ew || dout !== ed) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random_cyc%0d got g=%b%b a=%h w=%b d=%h want owner=%0d a=%h w=%b d=%h",
                   i, m0_grant, m1_grant, address, wr, dout, own, ea, ew, ed);
      end
      nxt = model_next(own, last, tenure, m0_req, m1_req);
      tick();
      if (nxt == 0) tenure = 0;
      else if (nxt != own) tenure = 1;
      else tenure++;
      if (nxt != 0) last = nxt - 1;
      own = nxt;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_handover();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master bus arbiter that sits directly upstream of the address decoder. It grants the shared bus to one of two masters (M0, M1) with round-robin fairness. It muxes the granted master's address, write strobe and write data onto the single shared bus. The shared address feeds the decoder, whose address[7:5] picks matrix, RAM A, RAM B or RAM C. When no master is granted, the bus parks on an address that decodes to no slave.

## Interface

Parameters:
- DATA_W, 32, width of write-data path
- MAX_HOLD, 16, max consecutive grant cycles while the other master waits (used only with the timeout option; legal range 2..255)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset; asynchronous, active-low
- m0_req  in  1  M0 bus request, level; held for the whole tenure
- m0_address  in  8  M0 address
- m0_wr  in  1  M0 write strobe
- m0_dout  in  DATA_W  M0 write data
- m1_req, m1_address, m1_wr, m1_dout  in  1/8/1/DATA_W  same as M0, for M1
- m0_grant  out  1  M0 owns bus (registered)
- m1_grant  out  1  M1 owns bus (registered)
- address  out  8  shared bus address to decoder
- wr  out  1  shared write strobe
- dout  out  DATA_W  shared write data

## Operation

- States: IDLE, GRANT0, GRANT1, held in a state register. m0_grant is 1 only in GRANT0; m1_grant is 1 only in GRANT1.
- `last` bit: records the most recently granted master. It is set to 1 on reset, so M0 wins the first tie.
- IDLE:
  - only m0_req → GRANT0; only m1_req → GRANT1.
  - both → grant the master ≠ last.
  - none → stay in IDLE.
- GRANT0:
  - m0_req high → stay.
  - m0_req low and m1_req high → GRANT1 directly, with no IDLE bubble.
  - both low → IDLE.
- GRANT1 is symmetric to GRANT0.
- `last` updates on every entry to GRANT0 (to 0) or GRANT1 (to 1).
- Bus mux (combinational from state):
  - GRANT0 → M0 signals; GRANT1 → M1 signals.
  - IDLE → address=8'hE0, wr=0, dout=0. 8'hE0 decodes to no slave (address[7:5]=3'b111).
- A master may change address/wr/dout every cycle while granted; the arbiter passes them through unregistered.
- A non-granted master's signals never reach the bus.

## Timing

- Reset values: state=IDLE, last=1, m0_grant=0, m1_grant=0, address=8'hE0, wr=0, dout=0, hold counter=0.
- Reset assertion mid-tenure drops the grant and parks the bus immediately (asynchronously), not at the next edge.
- Request-to-grant latency is 1 cycle when the bus is idle. A req seen at edge N gives grant high after edge N; the bus carries that master's signals from then on.
- Release:
  - req low at edge N → grant low after edge N.
  - A waiting master is granted at the same edge, giving a back-to-back handover with zero idle cycles.
- A master must hold wr low during the cycle its req drops; the arbiter does not check this.
- A master must not assume a grant until it samples grant=1.

## Configuration

- BUS_ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on every grant entry and increments each cycle in GRANT0/GRANT1, saturating at MAX_HOLD-1.
  - If the counter equals MAX_HOLD-1 and the other master is requesting, the next edge forces a switch to the other master. The preempted master's req may still be high; it re-competes via round-robin.
  - If the other master is not requesting, the owner keeps the bus and the counter stays saturated.
- BUS_ARB_TIMEOUT_EN undefined: no counter is built. A master holds the bus for as long as its req stays high, and MAX_HOLD is ignored.

## Test plan

- Reset check: assert reset_n=0 mid-tenure (M0 granted, address=8'h25).
  - Grants drop to 0 at once.
  - address=8'hE0, wr=0 without waiting for a clock edge.
- Single master: m1_req=1 with m1_address=8'h41, m1_wr=1.
  - m1_grant=1 one cycle later; address=8'h41, wr=1.
  - Drop m1_req → IDLE and address=8'hE0 next cycle.
- Tie after reset: both req rise in the same cycle.
  - m0_grant first.
  - Next simultaneous tie from IDLE grants M1.
- Handover: M0 granted, M1 requesting, m0_req drops at edge N.
  - m1_grant=1 after edge N; no IDLE cycle.
  - address switches from m0_address to m1_address (e.g. 8'h10 → 8'h70).
- Timeout with BUS_ARB_TIMEOUT_EN, MAX_HOLD=4: M0 holds req, M1 requests from cycle 1.
  - M1 granted after 4 M0-grant cycles.
- Timeout without BUS_ARB_TIMEOUT_EN, same stimulus:
  - M0 keeps the grant for 100 cycles; M1 is granted only after m0_req drops.
